rx_engine: RTL and testbench
============================

# rx_engine

UART receive engine: the serial-in counterpart of the transmit engine, sharing its frame format and baud selection (`baud_in`, `Eight`, `Pen`, `OHEL`). It recovers frames from the `rx` line and presents one byte plus error flags to the processor port. The processor clears the byte through a port-mapped read strobe. Single 100 MHz clock domain; `rx` is asynchronous.

## Interface
- `DATA_PORT`, default 16'h0000: `port_id` value whose `read_strobe` consumes the received byte.
- `clk` in 1: 100 MHz system clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx` in 1: serial line, idle high, asynchronous.
- `baud_in` in 4: baud select, same encoding as transmit.
- `Eight` in 1: 1 = 8 data bits, 0 = 7 data bits.
- `Pen` in 1: parity enable.
- `OHEL` in 1: parity sense, 1 = odd, 0 = even.
- `port_id` in 16: processor port address.
- `read_strobe` in 1: one-cycle processor read pulse.
- `rx_data` out 8: received byte; bit 7 is 0 in 7-bit mode.
- `rx_rdy` out 1: byte available.
- `perr` out 1: parity error for the held byte.
- `ferr` out 1: framing error (stop bit sampled low).
- `ovf` out 1: overrun (new byte loaded while `rx_rdy` was 1).

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) and then an edge register. A start is a synchronized falling edge seen in IDLE.
- Bit time N (clock cycles) by `baud_in`: 0:333333, 1:83333, 2:41667, 3:20833, 4:10417, 5:5208, 6:2604, 7:1736, 8:868, 9:434, 10:217, 11–15:109. The counter is 19 bits.
- Frame: start, 7 or 8 data bits LSB first, parity bit if `Pen`, one stop bit. Bits after start: 8 + `Eight` + `Pen`.
- `baud_in`, `Eight`, `Pen` and `OHEL` are latched at start detection and held for the whole frame.
- States and transitions:
  - IDLE → START on falling edge.
  - START: wait N/2 (integer divide), then sample. Low → DATA. High → IDLE (false start, no flags changed).
  - DATA: sample every N cycles; a down-counter holds the remaining bits. After the last data/parity bit → STOP.
  - STOP: sample after N, then LOAD.
  - LOAD (one cycle): update outputs, then → IDLE.
- Parity: expected bit = `^data` XOR `OHEL`, taken over 7 or 8 bits. `perr` = received parity ≠ expected. `perr` is 0 when `Pen`=0.
- LOAD updates `rx_data`, `perr`, `ferr` (stop sample == 0), and sets `rx_rdy`=1. `ovf` is set to 1 if `rx_rdy` was already 1 and was not being cleared that same cycle; otherwise `ovf` holds its value.
- `read_strobe` && `port_id`==`DATA_PORT` clears `rx_rdy`, `ovf`, `perr` and `ferr`. If it coincides with LOAD, LOAD wins: `rx_rdy`=1, new flags, `ovf`=0.
- A line held low after a framing error does not retrigger, because a new start needs a fresh falling edge.

## Timing
- Reset values: `rx_data`=0, `rx_rdy`=0, `perr`=0, `ferr`=0, `ovf`=0, state IDLE, synchronizer=1.
- Start sample occurs N/2 cycles after edge detection, which is 2–3 cycles after the pin edge. Bit k (k=1..) is sampled at N/2 + k·N after detection.
- Outputs update on the clock edge one cycle after the stop sample. `rx_rdy` rises at the same edge as `rx_data`.
- Asserting `reset` mid-frame aborts immediately. The next falling edge after release starts a clean frame.
- Back-to-back frames are supported: IDLE is re-entered mid-stop-bit, before the next start edge.

## Configuration
- `RX_ENGINE_MAJORITY_EN` defined: each sample is a 2-of-3 majority of the synchronized line at sample point −1, 0 and +1 cycle. The start-bit qualification uses the same vote. Sample points do not move.
- Undefined: single sample at the sample point.

## Structure
- Shared package `uart_pkg`: baud count table, counter width constant (19), state encoding, frame-length helper. The transmit engine uses the same package.
- One sub-module, `rx_bit_timer`. It is loaded with N/2 or N, counts down, and emits a one-cycle `sample` tick; a `clear` input restarts it. The FSM, shift register, parity and flag logic stay in `rx_engine`.

## Test plan
Directed scenarios, all at `baud_in`=11 (N=109) unless noted:
- 8N1 frame of 8'h31 (`Eight`=1, `Pen`=0) → `rx_data`=8'h31, `rx_rdy`=1, all flags 0. A read on `DATA_PORT` → `rx_rdy`=0 next cycle.
- 7-bit even parity (`Eight`=0, `Pen`=1, `OHEL`=0), 7'h31 with parity 1 → `rx_data`=8'h31, `perr`=0. The same frame with parity 0 → `perr`=1.
- 8N1 8'hA5 with stop bit driven 0 → `rx_data`=8'hA5, `ferr`=1. Line held low afterward → no second `rx_rdy` until a high-to-low edge.
- Two 8N1 frames (8'h11 then 8'h22) with no read → `rx_data`=8'h22, `ovf`=1. Read strobe coincident with the second LOAD → `ovf`=0, `rx_rdy`=1.
- 30-cycle low glitch in IDLE → no `rx_rdy` and state back in IDLE. With `RX_ENGINE_MAJORITY_EN`, a 1-cycle glitch at a mid-bit sample point does not corrupt the byte.
- `reset` low for 5 cycles during bit 4 → all outputs 0. The next 8N1 frame of 8'h5A at `baud_in`=8 (N=868) is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ==========================================================================
// uart_pkg : baud table, counter width, state encoding, frame helper
// Rev 1.0
// ==========================================================================
package uart_pkg;

    localparam int BAUD_CNT_W = 19;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        LOAD  = 3'd4
    } uart_state_t;

    function automatic logic [BAUD_CNT_W-1:0] baud_count(input logic [3:0] sel);
        case (sel)
            4'd0:    baud_count = 19'd333333;
            4'd1:    baud_count = 19'd83333;
            4'd2:    baud_count = 19'd41667;
            4'd3:    baud_count = 19'd20833;
            4'd4:    baud_count = 19'd10417;
            4'd5:    baud_count = 19'd5208;
            4'd6:    baud_count = 19'd2604;
            4'd7:    baud_count = 19'd1736;
            4'd8:    baud_count = 19'd868;
            4'd9:    baud_count = 19'd434;
            4'd10:   baud_count = 19'd217;
            default: baud_count = 19'd109;
        endcase
    endfunction

    // Bits following the start bit: data, optional parity, stop.
    function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
        return 4'd8 + {3'd0, eight} + {3'd0, pen};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_bit_timer.sv
`default_nettype none
// ==========================================================================
// rx_bit_timer : loadable down-counter emitting a one-cycle sample tick
// Rev 1.0
// ==========================================================================
module rx_bit_timer
    import uart_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [BAUD_CNT_W-1:0] load_val,
    input  logic [BAUD_CNT_W-1:0] period,
    input  logic                  clear,
    output logic                  sample
);

    logic [BAUD_CNT_W-1:0] count;
    logic                  running;

    // After each tick the counter reloads a full bit period on its own.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            running <= 1'b0;
        end else if (clear) begin
            running <= 1'b0;
        end else if (load) begin
            count   <= load_val - 1'b1;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0)
                count <= period - 1'b1;
            else
                count <= count - 1'b1;
        end
    end

    assign sample = running && (count == '0);

endmodule
`default_nettype wire

// File: rtl/rx_engine.sv
`default_nettype none
// ==========================================================================
// rx_engine : UART receive engine with port-mapped read clear
// Option: RX_ENGINE_MAJORITY_EN selects 2-of-3 voting per sample. Rev 1.0
// ==========================================================================
module rx_engine
    import uart_pkg::*;
#(
    parameter logic [15:0] DATA_PORT = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [3:0]  baud_in,
    input  logic        Eight,
    input  logic        Pen,
    input  logic        OHEL,
    input  logic [15:0] port_id,
    input  logic        read_strobe,
    output logic [7:0]  rx_data,
    output logic        rx_rdy,
    output logic        perr,
    output logic        ferr,
    output logic        ovf
);

    uart_state_t state, state_nx;
    logic        sync1, sync2, line_prev, fall;
    logic [3:0]  baud_l;
    logic        eight_l, pen_l, ohel_l;
    logic [3:0]  bits_left;
    logic [8:0]  shreg;
    logic        stop_bit;
    logic        tick, smp, bit_val, rd_hit, tmr_load, tmr_clear;
    logic [3:0]  shift_amt;
    logic [8:0]  aligned;
    logic [7:0]  byte_nx;
    logic        par_rx, perr_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= rx;
            sync2     <= sync1;
            line_prev <= sync2;
        end
    end

    assign fall = line_prev & ~sync2;

`ifdef RX_ENGINE_MAJORITY_EN
    // Decision lands one cycle after the tick so the +1 sample is available.
    logic [1:0] hist;
    logic       tick_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist   <= 2'b11;
            tick_d <= 1'b0;
        end else begin
            hist   <= {hist[0], sync2};
            tick_d <= tick;
        end
    end

    assign smp     = tick_d;
    assign bit_val = (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
`else
    assign smp     = tick;
    assign bit_val = sync2;
`endif

    rx_bit_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (baud_count(baud_in) >> 1),
        .period   (baud_count(baud_l)),
        .clear    (tmr_clear),
        .sample   (tick)
    );

    always_comb begin
        state_nx  = state;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        case (state)
            IDLE:  if (fall) begin
                       state_nx = START;
                       tmr_load = 1'b1;
                   end
            START: if (smp) begin
                       if (bit_val) begin
                           state_nx  = IDLE;
                           tmr_clear = 1'b1;
                       end else begin
                           state_nx  = DATA;
                       end
                   end
            DATA:  if (smp && bits_left == 4'd1) state_nx = STOP;
            STOP:  if (smp) state_nx = LOAD;
            default: begin
                state_nx  = IDLE;
                tmr_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            baud_l    <= 4'd0;
            eight_l   <= 1'b1;
            pen_l     <= 1'b0;
            ohel_l    <= 1'b0;
            bits_left <= 4'd0;
            shreg     <= 9'd0;
            stop_bit  <= 1'b1;
        end else begin
            state <= state_nx;
            if (state == IDLE && fall) begin
                baud_l  <= baud_in;
                eight_l <= Eight;
                pen_l   <= Pen;
                ohel_l  <= OHEL;
            end
            if (state == START && smp)
                bits_left <= frame_bits(eight_l, pen_l) - 4'd1;
            if (state == DATA && smp) begin
                shreg     <= {bit_val, shreg[8:1]};
                bits_left <= bits_left - 4'd1;
            end
            if (state == STOP && smp)
                stop_bit <= bit_val;
        end
    end

    // Short frames leave their bits at the top of the shift register.
    assign shift_amt = 4'd10 - frame_bits(eight_l, pen_l);
    assign aligned   = shreg >> shift_amt;
    assign byte_nx   = eight_l ? aligned[7:0] : {1'b0, aligned[6:0]};
    assign par_rx    = eight_l ? aligned[8] : aligned[7];
    assign perr_nx   = pen_l & (par_rx ^ (^byte_nx) ^ ohel_l);
    assign rd_hit    = read_strobe && (port_id == DATA_PORT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data <= 8'd0;
            rx_rdy  <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else if (state == LOAD) begin
            rx_data <= byte_nx;
            perr    <= perr_nx;
            ferr    <= ~stop_bit;
            rx_rdy  <= 1'b1;
            if (rd_hit)
                ovf <= 1'b0;
            else if (rx_rdy)
                ovf <= 1'b1;
        end else if (rd_hit) begin
            rx_rdy <= 1'b0;
            ovf    <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_engine.sv
`default_nettype none
// ==========================================================================
// tb_rx_engine : directed scenarios with an expected-frame queue
// Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
module tb_rx_engine;
    import uart_pkg::*;

    localparam logic [15:0] PORT = 16'h00A0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic [3:0]  baud_in = 4'd11;
    logic        Eight = 1'b1, Pen = 1'b0, OHEL = 1'b0;
    logic [15:0] port_id = 16'h0000;
    logic        read_strobe = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_rdy, perr, ferr, ovf;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;
    exp_t sb[$];

    rx_engine #(.DATA_PORT(PORT)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .baud_in     (baud_in),
        .Eight       (Eight),
        .Pen         (Pen),
        .OHEL        (OHEL),
        .port_id     (port_id),
        .read_strobe (read_strobe),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .perr        (perr),
        .ferr        (ferr),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic int bit_time(input logic [3:0] sel);
        case (sel)
            4'd8:    return 868;
            4'd9:    return 434;
            4'd10:   return 217;
            default: return 109;
        endcase
    endfunction

    // Drives one frame and queues the result the receiver should present.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int glitch_bit);
        int         n;
        int         nb;
        logic [10:0] bits;
        logic [7:0] dv;
        exp_t       e;
        n  = bit_time(baud_in);
        dv = Eight ? d : {1'b0, d[6:0]};
        e.data = dv;
        e.perr = Pen && (par != ((^dv) ^ OHEL));
        e.ferr = !stop;
        sb.push_back(e);
        bits = '0;
        nb   = 1;
        for (int i = 0; i < (Eight ? 8 : 7); i++) begin
            bits[nb] = dv[i];
            nb++;
        end
        if (Pen) begin
            bits[nb] = par;
            nb++;
        end
        bits[nb] = stop;
        nb++;
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            if (i == glitch_bit) begin
                repeat (n / 2) @(negedge clk);
                rx = ~bits[i];
                @(negedge clk);
                rx = bits[i];
                repeat (n - n / 2 - 1) @(negedge clk);
            end else begin
                repeat (n) @(negedge clk);
            end
        end
    endtask

    task automatic do_read(input logic [15:0] addr);
        @(negedge clk);
        port_id     = addr;
        read_strobe = 1'b1;
        @(negedge clk);
        read_strobe = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        vectors++; if (rx_rdy !== 1'b0) begin errors++; $display("FAIL reset_rx_rdy: got %b expected 0", rx_rdy); end
        vectors++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", perr); end
        vectors++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
        vectors++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        reset = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_8n1;
        exp_t e;
        Eight = 1'b1; Pen = 1'b0; OHEL = 1'b0;
        send_frame(8'h31, 1'b0, 1'b1, -1);
        vectors++;
        if (sb.size() == 0) begin errors++; $display("FAIL 8n1_queue: got empty expected 1 entry"); end
        else begin
            e = sb.pop_front();
            if ({rx_rdy, ovf, perr, ferr, rx_data} !== {1'b1, 1'b0, e.perr, e.ferr, e.data}) begin
                errors++;
                $display("FAIL 8n1: got rdy=%b ovf=%b perr=%b ferr=%b data=%h expected rdy=1 ovf=0 perr=%b ferr=%b data=%h",
                         rx_rdy, ovf, perr, ferr, rx_data, e.perr, e.ferr, e.data);
            end
        end
        do_read(16'h0001);
        vectors++; if (rx_rdy !== 1'b1) begin errors++; $display("FAIL wrong_port_read: got rdy=%b expected 1", rx_rdy); end
        do_read(PORT);
        vectors++; if (rx_rdy !== 1'b0) begin errors++; $display("FAIL data_port_read: got rdy=%b expected 0", rx_rdy); end
    endtask

    task automatic test_parity;
        exp_t e;
        logic good;
        Eight = 1'b0; Pen = 1'b1; OHEL = 1'b0;
        good = (^8'h31) ^ OHEL;
        for (int k = 0; k < 2; k++) begin
            send_frame(8'h31, (k == 0) ? good : ~good, 1'b1, -1);
            vectors++;
            if (sb.size() == 0) begin errors++; $display("FAIL parity_queue: got empty expected 1 entry"); end
            else begin
                e = sb.pop_front();
                if ({rx_rdy, perr, ferr, rx_data} !== {1'b1, e.perr, e.ferr, e.data} || e.perr !== (k == 1)) begin
                    errors++;
                    $display("FAIL parity_%0d: got rdy=%b perr=%b ferr=%b data=%h expected rdy=1 perr=%b ferr=%b data=%h",
                             k, rx_rdy, perr, ferr, rx_data, e.perr, e.ferr, e.data);
                end
            end
            do_read(PORT);
        end
    endtask

    task automatic test_framing;
        exp_t e;
        Eight = 1'b1; Pen = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, -1);
        vectors++;
        if (sb.size() == 0) begin errors++; $display("FAIL framing_queue: got empty expected 1 entry"); end
        else begin
            e = sb.pop_front();
            if ({rx_rdy, ferr, rx_data} !== {1'b1, e.ferr, e.data} || !e.ferr) begin
                errors++;
                $display("FAIL framing: got rdy=%b ferr=%b data=%h expected rdy=1 ferr=1 data=%h",
                         rx_rdy, ferr, rx_data, e.data);
            end
        end
        do_read(PORT);
        repeat (1500) @(negedge clk);
        vectors++; if (rx_rdy !== 1'b0) begin errors++; $display("FAIL held_low_retrigger: got rdy=%b expected 0", rx_rdy); end
        rx = 1'b1;
        repeat (220) @(negedge clk);
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        vectors++;
        if (sb.size() == 0) begin errors++; $display("FAIL after_edge_queue: got empty expected 1 entry"); end
        else begin
            e = sb.pop_front();
            if ({rx_rdy, ferr, perr, rx_data} !== {1'b1, e.ferr, e.perr, e.data}) begin
                errors++;
                $display("FAIL after_edge: got rdy=%b ferr=%b perr=%b data=%h expected rdy=1 ferr=0 perr=0 data=%h",
                         rx_rdy, ferr, perr, rx_data, e.data);
            end
        end
        do_read(PORT);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [7:0] d [4];
        logic       found;
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h44; d[3] = 8'h55;
        Eight = 1'b1; Pen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            if (k == 3) begin
                fork
                    send_frame(d[k], 1'b0, 1'b1, -1);
                    begin
                        for (int i = 0; i < 3000; i++) begin
                            @(negedge clk);
                            if (dut.state == LOAD) begin
                                port_id     = PORT;
                                read_strobe = 1'b1;
                                @(negedge clk);
                                read_strobe = 1'b0;
                                found = 1'b1;
                                break;
                            end
                        end
                    end
                join
                vectors++;
                if (!found) begin errors++; $display("FAIL load_wait: got timeout expected LOAD cycle"); end
            end else begin
                send_frame(d[k], 1'b0, 1'b1, -1);
            end
            vectors++;
            if (sb.size() == 0) begin errors++; $display("FAIL b2b_queue_%0d: got empty expected 1 entry", k); end
            else begin
                e = sb.pop_front();
                if ({rx_rdy, ovf, rx_data} !== {1'b1, (k == 1), e.data}) begin
                    errors++;
                    $display("FAIL b2b_%0d: got rdy=%b ovf=%b data=%h expected rdy=1 ovf=%b data=%h",
                             k, rx_rdy, ovf, rx_data, (k == 1), e.data);
                end
            end
            if (k == 1) do_read(PORT);
        end
        do_read(PORT);
    endtask

    task automatic test_glitch;
        exp_t e;
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        vectors++; if (rx_rdy !== 1'b0) begin errors++; $display("FAIL glitch_rdy: got %b expected 0", rx_rdy); end
        vectors++; if (dut.state !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dut.state, IDLE); end
`ifdef RX_ENGINE_MAJORITY_EN
        Eight = 1'b1; Pen = 1'b0;
        send_frame(8'h96, 1'b0, 1'b1, 4);
        vectors++;
        if (sb.size() == 0) begin errors++; $display("FAIL vote_queue: got empty expected 1 entry"); end
        else begin
            e = sb.pop_front();
            if ({rx_rdy, rx_data} !== {1'b1, e.data}) begin
                errors++;
                $display("FAIL vote_glitch: got rdy=%b data=%h expected rdy=1 data=%h", rx_rdy, rx_data, e.data);
            end
        end
        do_read(PORT);
`else
        e = '0;
`endif
    endtask

    task automatic test_reset_midframe;
        exp_t e;
        logic [7:0] d;
        Eight = 1'b1; Pen = 1'b0;
        send_frame(8'hC3, 1'b0, 1'b0, -1);
        if (sb.size() != 0) e = sb.pop_front();
        rx = 1'b1;
        repeat (120) @(negedge clk);
        send_frame(8'hC3, 1'b0, 1'b1, -1);
        if (sb.size() != 0) e = sb.pop_front();
        // Partial frame: start plus four data bits, reset lands inside bit 4.
        d  = 8'h5A;
        rx = 1'b0;
        repeat (109) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (109) @(negedge clk);
        end
        rx = d[4];
        repeat (50) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if ({rx_data, rx_rdy, perr, ferr, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL midframe_reset: got data=%h rdy=%b perr=%b ferr=%b ovf=%b expected all 0",
                     rx_data, rx_rdy, perr, ferr, ovf);
        end
        reset = 1'b1;
        rx    = 1'b1;
        repeat (20) @(negedge clk);
        baud_in = 4'd8;
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        vectors++;
        if (sb.size() == 0) begin errors++; $display("FAIL post_reset_queue: got empty expected 1 entry"); end
        else begin
            e = sb.pop_front();
            if ({rx_rdy, ovf, perr, ferr, rx_data} !== {1'b1, 1'b0, e.perr, e.ferr, e.data}) begin
                errors++;
                $display("FAIL post_reset_frame: got rdy=%b ovf=%b perr=%b ferr=%b data=%h expected rdy=1 ovf=0 perr=0 ferr=0 data=%h",
                         rx_rdy, ovf, perr, ferr, rx_data, e.data);
            end
        end
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_parity;
        test_framing;
        test_back_to_back;
        test_glitch;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
